pipeline_execute_memory: RTL and testbench
==========================================

// Module: pipeline_execute_memory
// PURPOSE
// EX/MEM pipeline register: captures execute-stage results each enabled cycle, drives the data-memory request,
// and holds that request until dhit. Sits between execute (downstream of the decode/execute latch) and MEM/WB.
// Owns a small request FSM, so a completed access is never re-issued while the rest of the pipe stalls on ihit.
// PARAMETERS
// RESET_PC  32'h0000_0000  reset value of pc4_mem
// PORTS (connected through pipeline_if modport em; listed flat here)
// CLK             in   1   system clock, rising edge
// nRST            in   1   asynchronous, active-low reset
// em_state        in   2   pipe_state_t from hazard unit: PIPE_ENABLE / PIPE_STALL / PIPE_NOP
// RegWrite_ex     in   1   write-back enable from EX
// MemToReg_ex     in   1   write-back select (memory vs ALU)
// dREN_ex         in   1   load in EX
// dWEN_ex         in   1   store in EX
// halt_ex         in   1   halt instruction in EX
// alu_out_ex      in   32  ALU result / effective address
// store_dat_ex    in   32  forwarded rt value for stores
// wsel_ex         in   5   destination register (after RegDst mux)
// pc4_ex          in   32  PC+4 (JAL link value)
// dhit            in   1   data cache access complete this cycle
// dmemload        in   32  data cache read data, valid with dhit
// RegWrite_mem, MemToReg_mem, halt_mem  out  1 each  registered controls
// alu_out_mem     out  32  registered ALU result
// wsel_mem        out  5   registered destination
// pc4_mem         out  32  registered PC+4
// dmemREN         out  1   cache read request
// dmemWEN         out  1   cache write request
// dmemaddr        out  32  = alu_out_mem
// dmemstore       out  32  registered store data
// dload_mem       out  32  load data to MEM/WB
// mem_busy        out  1   request outstanding and no dhit; hazard unit stalls upstream
// BEHAVIOUR
// - Reset: every register output 0 (pc4_mem = RESET_PC); FSM = M_IDLE; dmemREN = dmemWEN = 0; mem_busy = 0.
// - FSM mem_req_t {M_IDLE, M_REQ, M_DONE}:
//   capture (effective ENABLE) with dREN_ex|dWEN_ex -> M_REQ; capture without either -> M_IDLE.
//   M_REQ & dhit -> M_DONE; M_REQ & !dhit -> M_REQ. M_DONE holds until the next capture or NOP.
// - dmemREN = (state==M_REQ) & dREN_q; dmemWEN = (state==M_REQ) & dWEN_q. Both are 0 in IDLE/DONE, even when stalled.
// - mem_busy = (state==M_REQ) & !dhit (combinational).
// - Effective state: if mem_busy, ENABLE and NOP both act as STALL, so an outstanding access is never dropped or replaced.
// - ENABLE (not busy): all *_mem registers <= *_ex at the edge; dREN_q/dWEN_q <= dREN_ex/dWEN_ex. Latency: 1 cycle EX->MEM.
// - STALL: all registers hold; FSM still advances on dhit.
// - NOP (not busy): all data/control registers <= 0 (pc4_mem <= 0); FSM -> M_IDLE.
// - Load data: dload_q <= dmemload when state==M_REQ & dhit.
//   dload_mem = (state==M_REQ & dhit) ? dmemload : dload_q, so MEM/WB can capture on the same edge the access completes.
// - Same-cycle dhit + ENABLE in M_REQ: old access completes (dload_q updated), new instruction captured, FSM follows the new instruction.
// - halt_mem is sticky: set on capture of halt_ex=1, cleared only by nRST; NOP does not clear it.
// - Reset mid-request: FSM -> M_IDLE immediately and the request drops the same cycle. The cache is reset by the same nRST.
// - dREN_ex & dWEN_ex both 1 is illegal from decode; if it occurs, dmemWEN takes priority and dmemREN is forced to 0.
// STRUCTURE
// - cpu_types_pkg: add typedef enum logic [1:0] mem_req_t {M_IDLE, M_REQ, M_DONE}.
//   Reuse the existing pipe_state_t, word_t and regbits_t.
// - pipeline_if: add modport em with the ports above.
// - One natural sub-module: dmem_req_fsm (FSM, dmemREN/dmemWEN, mem_busy, dload_q). The latch body stays inline.
// TESTING
// 1 Reset: assert nRST=0 mid-run -> all outputs 0, dmemREN=0, mem_busy=0 within the same cycle.
// 2 ALU op: ENABLE with alu_out_ex=32'h0000_0010, wsel_ex=5'd8, RegWrite_ex=1 -> next cycle alu_out_mem=0x10,
//   wsel_mem=8, dmemREN=dmemWEN=0.
// 3 Load, dhit after 3 cycles: dREN_ex=1, alu_out_ex=32'h0000_0F00 -> dmemREN=1 and dmemaddr=0xF00 for 3 cycles,
//   mem_busy=1 for 2 cycles; on dhit with dmemload=32'hDEAD_BEEF, dload_mem=0xDEADBEEF; next cycle dmemREN=0.
// 4 Store, then em_state=STALL for 4 cycles after dhit -> dmemWEN=1 exactly until dhit, 0 through the stall; dmemstore held.
// 5 ENABLE and NOP during busy: both ignored; registers unchanged until dhit.
//   dhit + ENABLE same cycle: new instruction captured and dload_mem shows the old load data on that cycle.
// 6 halt_ex=1 captured, then NOP x3 -> halt_mem stays 1; cleared only by nRST.

Source files
------------

// File: rtl/pipeline_execute_memory_pkg.sv
// Shared CPU types for the EX/MEM pipeline register and its data-memory request FSM.
package pipeline_execute_memory_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_REQ  = 2'd1,
        M_DONE = 2'd2
    } mem_req_t;

endpackage

// File: rtl/pipeline_execute_memory_dmem_req_fsm.sv
// Data-memory request FSM: issues the read/write until dhit, then parks so a
// completed access is not re-issued while the pipe is stalled.
module dmem_req_fsm
    import pipeline_execute_memory_pkg::*;
(
    input  logic  clk,
    input  logic  n_rst,
    input  logic  capture,
    input  logic  flush,
    input  logic  dren_ex,
    input  logic  dwen_ex,
    input  logic  dhit,
    input  word_t dmemload,
    output logic  dmem_ren,
    output logic  dmem_wen,
    output logic  mem_busy,
    output word_t dload_mem
);

    mem_req_t state_q, state_d;
    logic     dren_q, dren_d;
    logic     dwen_q, dwen_d;
    word_t    dload_q, dload_d;
    logic     done_now;

    assign done_now = (state_q == M_REQ) && dhit;

    always_comb begin
        state_d = state_q;
        dren_d  = dren_q;
        dwen_d  = dwen_q;
        dload_d = dload_q;
        if (done_now) begin
            dload_d = dmemload;
        end
        // A capture on the completing cycle replaces the finished access outright.
        if (capture) begin
            state_d = (dren_ex || dwen_ex) ? M_REQ : M_IDLE;
            dwen_d  = dwen_ex;
            dren_d  = dren_ex && !dwen_ex;
        end else if (flush) begin
            state_d = M_IDLE;
            dren_d  = 1'b0;
            dwen_d  = 1'b0;
        end else if (done_now) begin
            state_d = M_DONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= M_IDLE;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
            dload_q <= dload_d;
        end
    end

    assign dmem_ren  = (state_q == M_REQ) && dren_q;
    assign dmem_wen  = (state_q == M_REQ) && dwen_q;
    assign mem_busy  = (state_q == M_REQ) && !dhit;
    assign dload_mem = done_now ? dmemload : dload_q;

endmodule

// File: rtl/pipeline_execute_memory.sv
// EX/MEM pipeline register: latches execute results and drives the data-cache
// request, holding the pipe while an access is outstanding.
module pipeline_execute_memory
    import pipeline_execute_memory_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  em_state,
    input  logic        RegWrite_ex,
    input  logic        MemToReg_ex,
    input  logic        dREN_ex,
    input  logic        dWEN_ex,
    input  logic        halt_ex,
    input  logic [31:0] alu_out_ex,
    input  logic [31:0] store_dat_ex,
    input  logic [4:0]  wsel_ex,
    input  logic [31:0] pc4_ex,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        RegWrite_mem,
    output logic        MemToReg_mem,
    output logic        halt_mem,
    output logic [31:0] alu_out_mem,
    output logic [4:0]  wsel_mem,
    output logic [31:0] pc4_mem,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] dload_mem,
    output logic        mem_busy
);

    logic     capture, flush;
    logic     regwrite_q, regwrite_d;
    logic     memtoreg_q, memtoreg_d;
    logic     halt_q, halt_d;
    word_t    alu_out_q, alu_out_d;
    regbits_t wsel_q, wsel_d;
    word_t    pc4_q, pc4_d;
    word_t    store_q, store_d;

    // An outstanding access turns ENABLE and NOP into STALL.
    assign capture = (pipe_state_t'(em_state) == PIPE_ENABLE) && !mem_busy;
    assign flush   = (pipe_state_t'(em_state) == PIPE_NOP) && !mem_busy;

    always_comb begin
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        halt_d     = halt_q;
        alu_out_d  = alu_out_q;
        wsel_d     = wsel_q;
        pc4_d      = pc4_q;
        store_d    = store_q;
        if (capture) begin
            regwrite_d = RegWrite_ex;
            memtoreg_d = MemToReg_ex;
            halt_d     = halt_q || halt_ex;
            alu_out_d  = alu_out_ex;
            wsel_d     = wsel_ex;
            pc4_d      = pc4_ex;
            store_d    = store_dat_ex;
        end else if (flush) begin
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            alu_out_d  = '0;
            wsel_d     = '0;
            pc4_d      = '0;
            store_d    = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            halt_q     <= 1'b0;
            alu_out_q  <= '0;
            wsel_q     <= '0;
            pc4_q      <= RESET_PC;
            store_q    <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            halt_q     <= halt_d;
            alu_out_q  <= alu_out_d;
            wsel_q     <= wsel_d;
            pc4_q      <= pc4_d;
            store_q    <= store_d;
        end
    end

    dmem_req_fsm u_req_fsm (
        .clk       (CLK),
        .n_rst     (nRST),
        .capture   (capture),
        .flush     (flush),
        .dren_ex   (dREN_ex),
        .dwen_ex   (dWEN_ex),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .dmem_ren  (dmemREN),
        .dmem_wen  (dmemWEN),
        .mem_busy  (mem_busy),
        .dload_mem (dload_mem)
    );

    assign RegWrite_mem = regwrite_q;
    assign MemToReg_mem = memtoreg_q;
    assign halt_mem     = halt_q;
    assign alu_out_mem  = alu_out_q;
    assign wsel_mem     = wsel_q;
    assign pc4_mem      = pc4_q;
    assign dmemaddr     = alu_out_q;
    assign dmemstore    = store_q;

endmodule

// File: tb/tb_pipeline_execute_memory.sv
// Directed scoreboard bench for the EX/MEM register and its memory request FSM.
module tb_pipeline_execute_memory;

    localparam logic [31:0] RST_PC = 32'h0000_0400;
    localparam logic [1:0]  S_EN   = 2'd0;
    localparam logic [1:0]  S_ST   = 2'd1;
    localparam logic [1:0]  S_NOP  = 2'd2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  em_state;
    logic        RegWrite_ex, MemToReg_ex, dREN_ex, dWEN_ex, halt_ex;
    logic [31:0] alu_out_ex, store_dat_ex, pc4_ex;
    logic [4:0]  wsel_ex;
    logic        dhit;
    logic [31:0] dmemload;
    logic        RegWrite_mem, MemToReg_mem, halt_mem;
    logic [31:0] alu_out_mem, pc4_mem, dmemaddr, dmemstore, dload_mem;
    logic [4:0]  wsel_mem;
    logic        dmemREN, dmemWEN, mem_busy;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_execute_memory #(.RESET_PC(RST_PC)) dut (
        .CLK(CLK), .nRST(nRST), .em_state(em_state),
        .RegWrite_ex(RegWrite_ex), .MemToReg_ex(MemToReg_ex),
        .dREN_ex(dREN_ex), .dWEN_ex(dWEN_ex), .halt_ex(halt_ex),
        .alu_out_ex(alu_out_ex), .store_dat_ex(store_dat_ex),
        .wsel_ex(wsel_ex), .pc4_ex(pc4_ex),
        .dhit(dhit), .dmemload(dmemload),
        .RegWrite_mem(RegWrite_mem), .MemToReg_mem(MemToReg_mem), .halt_mem(halt_mem),
        .alu_out_mem(alu_out_mem), .wsel_mem(wsel_mem), .pc4_mem(pc4_mem),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dload_mem(dload_mem), .mem_busy(mem_busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] st, input logic rw, input logic m2r,
                         input logic ren, input logic wen, input logic hlt,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] ws, input logic [31:0] pc4);
        em_state     = st;
        RegWrite_ex  = rw;
        MemToReg_ex  = m2r;
        dREN_ex      = ren;
        dWEN_ex      = wen;
        halt_ex      = hlt;
        alu_out_ex   = alu;
        store_dat_ex = sd;
        wsel_ex      = ws;
        pc4_ex       = pc4;
    endtask

    initial begin
        nRST = 1'b0;
        dhit = 1'b0;
        dmemload = '0;
        drive(S_EN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        tick();
        // reset state
        push("rst_alu_out", 32'h0);
        push("rst_pc4", RST_PC);
        push("rst_dmemREN", 32'h0);
        push("rst_busy", 32'h0);
        chk(alu_out_mem);
        chk(pc4_mem);
        chk({31'b0, dmemREN});
        chk({31'b0, mem_busy});
        nRST = 1'b1;

        // ALU op
        drive(S_EN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd8, 32'h0000_0104);
        push("alu_alu_out", 32'h10);
        push("alu_wsel", 32'd8);
        push("alu_regwrite", 32'h1);
        push("alu_pc4", 32'h0000_0104);
        push("alu_dmemREN", 32'h0);
        push("alu_dmemWEN", 32'h0);
        tick();
        chk(alu_out_mem);
        chk({27'b0, wsel_mem});
        chk({31'b0, RegWrite_mem});
        chk(pc4_mem);
        chk({31'b0, dmemREN});
        chk({31'b0, dmemWEN});

        // load with dhit on the third request cycle
        drive(S_EN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0F00, 32'h0, 5'd9, 32'h0000_0108);
        tick();
        drive(S_ST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        for (int c = 0; c < 2; c++) begin
            push("ld_dmemREN", 32'h1);
            push("ld_addr", 32'h0000_0F00);
            push("ld_busy", 32'h1);
            #1;
            chk({31'b0, dmemREN});
            chk(dmemaddr);
            chk({31'b0, mem_busy});
            tick();
        end
        dhit = 1'b1;
        dmemload = 32'hDEAD_BEEF;
        push("ld_hit_dmemREN", 32'h1);
        push("ld_hit_busy", 32'h0);
        push("ld_hit_dload", 32'hDEAD_BEEF);
        #1;
        chk({31'b0, dmemREN});
        chk({31'b0, mem_busy});
        chk(dload_mem);
        tick();
        dhit = 1'b0;
        dmemload = 32'h0;
        push("ld_after_dmemREN", 32'h0);
        push("ld_after_dload", 32'hDEAD_BEEF);
        push("ld_after_memtoreg", 32'h1);
        #1;
        chk({31'b0, dmemREN});
        chk(dload_mem);
        chk({31'b0, MemToReg_mem});

        // store, dhit, then four stall cycles
        drive(S_EN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 32'h0000_010C);
        tick();
        drive(S_ST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        push("st_wen_c1", 32'h1);
        push("st_store_c1", 32'hCAFE_F00D);
        chk({31'b0, dmemWEN});
        chk(dmemstore);
        tick();
        dhit = 1'b1;
        push("st_wen_hit", 32'h1);
        push("st_busy_hit", 32'h0);
        #1;
        chk({31'b0, dmemWEN});
        chk({31'b0, mem_busy});
        tick();
        dhit = 1'b0;
        for (int c = 0; c < 4; c++) begin
            push("st_stall_wen", 32'h0);
            push("st_stall_store", 32'hCAFE_F00D);
            #1;
            chk({31'b0, dmemWEN});
            chk(dmemstore);
            tick();
        end

        // ENABLE and NOP ignored while busy; dhit + ENABLE same cycle
        drive(S_EN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 5'd4, 32'h0000_0110);
        tick();
        drive(S_EN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 5'd3, 32'h0000_0114);
        tick();
        push("busy_en_alu", 32'h0000_0300);
        push("busy_en_ren", 32'h1);
        push("busy_en_busy", 32'h1);
        chk(alu_out_mem);
        chk({31'b0, dmemREN});
        chk({31'b0, mem_busy});
        em_state = S_NOP;
        tick();
        push("busy_nop_alu", 32'h0000_0300);
        push("busy_nop_wsel", 32'd4);
        push("busy_nop_ren", 32'h1);
        chk(alu_out_mem);
        chk({27'b0, wsel_mem});
        chk({31'b0, dmemREN});
        em_state = S_EN;
        dhit = 1'b1;
        dmemload = 32'h1234_5678;
        push("hit_en_dload", 32'h1234_5678);
        #1;
        chk(dload_mem);
        tick();
        dhit = 1'b0;
        dmemload = 32'h0;
        push("hit_en_alu", 32'h0000_0400);
        push("hit_en_wsel", 32'd3);
        push("hit_en_ren", 32'h0);
        push("hit_en_dload_q", 32'h1234_5678);
        #1;
        chk(alu_out_mem);
        chk({27'b0, wsel_mem});
        chk({31'b0, dmemREN});
        chk(dload_mem);

        // dREN and dWEN together: write wins
        drive(S_EN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_00AA, 5'd0, 32'h0000_0118);
        tick();
        drive(S_ST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        push("both_wen", 32'h1);
        push("both_ren", 32'h0);
        chk({31'b0, dmemWEN});
        chk({31'b0, dmemREN});
        dhit = 1'b1;
        tick();
        dhit = 1'b0;

        // sticky halt
        drive(S_EN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0700, 32'h0, 5'd0, 32'h0000_011C);
        tick();
        push("halt_set", 32'h1);
        chk({31'b0, halt_mem});
        drive(S_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            tick();
            push("halt_nop", 32'h1);
            chk({31'b0, halt_mem});
        end
        push("nop_alu", 32'h0);
        push("nop_pc4", 32'h0);
        chk(alu_out_mem);
        chk(pc4_mem);
        drive(S_EN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0800, 32'h0, 5'd2, 32'h0000_0120);
        tick();
        push("halt_keep", 32'h1);
        chk({31'b0, halt_mem});

        // reset in the middle of a request
        drive(S_EN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 5'd7, 32'h0000_0124);
        tick();
        drive(S_ST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        push("pre_rst_ren", 32'h1);
        chk({31'b0, dmemREN});
        #2;
        nRST = 1'b0;
        push("mid_rst_ren", 32'h0);
        push("mid_rst_busy", 32'h0);
        push("mid_rst_alu", 32'h0);
        push("mid_rst_wsel", 32'h0);
        push("mid_rst_halt", 32'h0);
        push("mid_rst_pc4", RST_PC);
        #1;
        chk({31'b0, dmemREN});
        chk({31'b0, mem_busy});
        chk(alu_out_mem);
        chk({27'b0, wsel_mem});
        chk({31'b0, halt_mem});
        chk(pc4_mem);
        tick();
        nRST = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
